// File: rtl/fp_pkg.sv
// Shared single-precision field widths, constants and types
// for the FP datapath units.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int FP_BIAS = 127;

  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV,
    ROUND,
    DONE
  } fp_div_state_t;

  typedef struct packed {
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one single-precision operand.
// Denormals classify as zero.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] fp_in,
  output fp_class_t   cls
);

  logic exp_max;
  logic man_nz;

  assign exp_max = &fp_in[30:23];
  assign man_nz  = |fp_in[22:0];

  assign cls.sign    = fp_in[31];
  assign cls.exp     = fp_in[30:23];
  assign cls.man     = fp_in[22:0];
  assign cls.is_zero = ~|fp_in[30:23];
  assign cls.is_inf  = exp_max & ~man_nz;
  assign cls.is_nan  = exp_max & man_nz;

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle single-precision divider: restoring
// division, one quotient bit per cycle, RNE rounding.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter logic [31:0] QNAN_VALUE = FP_QNAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_result,
  output logic        flag_invalid,
  output logic        flag_divzero,
  output logic        flag_overflow
);

  fp_div_state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [9:0]  exp_q, exp_d;
  logic [24:0] rem_q, rem_d;
  logic [26:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        inv_q, inv_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;

  fp_class_t ca, cb;

  fp_classify u_cls_a (.fp_in(a_q), .cls(ca));
  fp_classify u_cls_b (.fp_in(b_q), .cls(cb));

  logic        sgn;
  logic [31:0] inf_res, zero_res;
  assign sgn      = ca.sign ^ cb.sign;
  assign inf_res  = {sgn, FP_POS_INF[30:0]};
  assign zero_res = {sgn, 31'd0};

  logic [23:0] mb;
  logic        ge;
  logic [24:0] diff;
  assign mb   = {1'b1, cb.man};
  assign ge   = rem_q >= {1'b0, mb};
  assign diff = rem_q - {1'b0, mb};

  logic [22:0] r_frac;
  logic        r_g, r_s, r_up;
  logic [9:0]  r_exp0, r_exp;
  logic [32:0] r_pk;

  assign r_frac = q_q[26] ? q_q[25:3] : q_q[24:2];
  assign r_g    = q_q[26] ? q_q[2] : q_q[1];
  assign r_s    = (q_q[26] ? |q_q[1:0] : q_q[0])
                | (rem_q != '0);
  assign r_exp0 = q_q[26] ? exp_q : exp_q - 10'd1;
  assign r_up   = r_g & (r_s | r_frac[0]);
  // Carry out of the fraction rolls into the exponent.
  assign r_pk   = {r_exp0, r_frac} + 33'(r_up);
  assign r_exp  = r_pk[32:23];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    inv_d   = inv_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          a_d     = fp_a;
          b_d     = fp_b;
          inv_d   = 1'b0;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = DONE;
        if (ca.is_nan | cb.is_nan) begin
          res_d = QNAN_VALUE;
          inv_d = 1'b1;
        end else if ((ca.is_zero & cb.is_zero)
                   | (ca.is_inf & cb.is_inf)) begin
          res_d = QNAN_VALUE;
          inv_d = 1'b1;
        end else if (ca.is_inf) begin
          res_d = inf_res;
        end else if (cb.is_zero) begin
          res_d = inf_res;
          dz_d  = 1'b1;
        end else if (ca.is_zero | cb.is_inf) begin
          res_d = zero_res;
        end else begin
          exp_d   = {2'b00, ca.exp} - {2'b00, cb.exp}
                  + 10'(FP_BIAS);
          rem_d   = {2'b01, ca.man};
          q_d     = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        q_d   = {q_q[25:0], ge};
        rem_d = (ge ? diff : rem_q) << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd26) state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
        if ($signed(r_exp) >= 10'sd255) begin
          res_d = inf_res;
          ovf_d = 1'b1;
        end else if ($signed(r_exp) <= 10'sd0) begin
          res_d = zero_res;
        end else begin
          res_d = {sgn, r_exp[7:0], r_pk[22:0]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy          = (state_q == CHECK)
                       | (state_q == DIV)
                       | (state_q == ROUND);
  assign done          = state_q == DONE;
  assign fp_result     = res_q;
  assign flag_invalid  = inv_q;
  assign flag_divzero  = dz_q;
  assign flag_overflow = ovf_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed table, timing corners
// and random operands against a long-division model.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] fp_a, fp_b;
  logic        busy, done;
  logic [31:0] fp_result;
  logic        flag_invalid, flag_divzero, flag_overflow;

  int checks = 0;
  int errors = 0;

  fp_div_iter dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .fp_a(fp_a),
    .fp_b(fp_b),
    .busy(busy),
    .done(done),
    .fp_result(fp_result),
    .flag_invalid(flag_invalid),
    .flag_divzero(flag_divzero),
    .flag_overflow(flag_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  function automatic logic [2:0] flags_now();
    return {flag_invalid, flag_divzero, flag_overflow};
  endfunction

  // Exact quotient by wide integer division, then RNE.
  function automatic void ref_div(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic [2:0]  f,
    output int          lat);
    logic s, an, bn, ai, bi, az, bz, g, st;
    int ea, eb, e, sh;
    logic [63:0] ma, mb, n, rm, mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = ea == 255 && a[22:0] != 0;
    bn = eb == 255 && b[22:0] != 0;
    ai = ea == 255 && a[22:0] == 0;
    bi = eb == 255 && b[22:0] == 0;
    az = ea == 0;
    bz = eb == 0;
    f = 3'b000;
    lat = 2;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r = 32'h7FC0_0000;
      f = 3'b100;
    end else if (ai) begin
      r = {s, 31'h7F80_0000};
    end else if (bz) begin
      r = {s, 31'h7F80_0000};
      f = 3'b010;
    end else if (az || bi) begin
      r = {s, 31'd0};
    end else begin
      lat = 30;
      ma = 64'h80_0000 | 64'(a[22:0]);
      mb = 64'h80_0000 | 64'(b[22:0]);
      n  = (ma << 40) / mb;
      rm = (ma << 40) % mb;
      e  = ea - eb + 127;
      if (n >= (64'd1 << 40)) sh = 17;
      else begin
        sh = 16;
        e  = e - 1;
      end
      mant = n >> sh;
      g  = n[sh-1];
      st = ((n & ((64'd1 << (sh - 1)) - 1)) != 0)
           || (rm != 0);
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 31'h7F80_0000};
        f = 3'b001;
      end else if (e <= 0) begin
        r = {s, 31'd0};
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
  endfunction

  task automatic run_op(input  logic [31:0] a,
                        input  logic [31:0] b,
                        output logic [31:0] r,
                        output logic [2:0]  f,
                        output int          lat,
                        output logic        busy0,
                        output logic [2:0]  f0);
    @(negedge clk);
    fp_a  = a;
    fp_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy0 = busy;
    f0    = flags_now();
    lat   = -1;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    r = fp_result;
    f = flags_now();
  endtask

  logic [31:0] r, er;
  logic [2:0]  f, ef, f0;
  logic        b0;
  int          lat, elat, seen;

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 30};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 30};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 3'b010, 2};
    vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 3'b010, 2};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 3'b100, 2};
    vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 2};
    vecs[6]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 3'b001, 30};
    vecs[7]  = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 3'b000, 30};
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100, 2};
    vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 2};
    vecs[10] = '{32'h00000000, 32'hBF800000, 32'h80000000, 3'b000, 2};
    vecs[11] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 3'b000, 2};

    reset = 1'b1;
    start = 1'b0;
    fp_a  = '0;
    fp_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", fp_result, 32'd0);
    chk("rst_flags", 32'(flags_now()), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, r, f, lat, b0, f0);
      chk($sformatf("v%0d_res", i), r, vecs[i].res);
      chk($sformatf("v%0d_flg", i), 32'(f), 32'(vecs[i].flg));
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy", i), 32'(b0), 32'd1);
      chk($sformatf("v%0d_clr", i), 32'(f0), 32'd0);
    end

    // done is a single-cycle pulse
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("held_res", fp_result, 32'h80000000);

    // start during DIV must be ignored
    @(negedge clk);
    fp_a  = 32'h40C00000;
    fp_b  = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == 10) begin
        fp_a  = 32'h3F800000;
        fp_b  = 32'h40400000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("ign_res", fp_result, 32'h40400000);
    chk("ign_lat", lat, 30);

    // back-to-back accept directly from DONE
    fp_a  = 32'h3F800000;
    fp_b  = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("b2b_res", fp_result, 32'h3EAAAAAB);
    chk("b2b_lat", lat, 30);

    // reset mid-operation
    @(negedge clk);
    fp_a  = 32'h40C00000;
    fp_b  = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res", fp_result, 32'd0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    chk("mid_rst_nodone", seen, 0);

    // random operands against the model
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (k % 4 != 0) begin
        a[30:23] = 8'($urandom_range(40, 215));
        b[30:23] = 8'($urandom_range(40, 215));
      end
      if (k % 25 == 3) b[30:23] = 8'd0;
      if (k % 25 == 7) a[30:23] = 8'd255;
      if (k % 25 == 11) begin
        a[30:23] = 8'd250;
        b[30:23] = 8'd3;
      end
      if (k % 25 == 13) begin
        a[30:23] = 8'd3;
        b[30:23] = 8'd250;
      end
      ref_div(a, b, er, ef, elat);
      run_op(a, b, r, f, lat, b0, f0);
      chk($sformatf("rnd%0d_res %h/%h", k, a, b), r, er);
      chk($sformatf("rnd%0d_flg", k), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d_lat", k), lat, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
